adc_peak_scan: RTL and testbench
================================

# adc_peak_scan

Parametrised successor to the fixed 4-channel ADC capture and peak-hold path. It sequences an ADC0809-class converter round-robin over `NCH` inputs and tracks a per-channel running maximum and minimum over a clearable window. It also flags converters that never answer, and publishes packed peak/valley vectors with a per-scan strobe. It sits between the external ADC pins and the downstream 32-bit-style result registers.

## Interface
- `NCH`, 4: channels scanned, 1..8 (address is 3 bits).
- `DW`, 8: sample width.
- `CLK_DIV`, 8: `adc_clock` half-period in `clock` cycles, ≥1.
- `TO_CYC`, 1024: eoc timeout in `clock` cycles per wait state.
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `en` in 1: scan enable, level.
- `clr` in 1: one-cycle pulse; opens a new peak/valley window and clears errors.
- `eoc` in 1: ADC end-of-conversion, asynchronous to `clock`.
- `adc_data` in DW: ADC tri-state bus, valid while `oe`=1.
- `adc_clock` out 1: free-running divided clock, 50% duty.
- `start`, `ale`, `oe` out 1 each: ADC controls.
- `address` out 3: ADC mux select.
- `sample_out` out DW: last captured sample.
- `sample_ch` out 3: channel of `sample_out`.
- `sample_valid` out 1: one-cycle strobe per capture.
- `scan_done` out 1: one-cycle strobe after channel `NCH-1` updates.
- `peak_out`, `valley_out` out NCH*DW: channel k at bits [k*DW +: DW], ch0 in the LSBs.
- `timeout_err` out NCH: sticky per-channel no-response flag.

## Operation
- `eoc` passes a 2-flop synchronizer; the FSM sees only `eoc_s`.
- FSM states:
  - IDLE: if `en`, go to ADDR with `ch`=current channel.
  - ADDR: drive `address`=ch for 1 cycle.
  - START: `ale`=`start`=1 for 2 cycles.
  - WAITL: wait `eoc_s`=0.
  - WAITH: wait `eoc_s`=1.
  - READ: `oe`=1 for 2 cycles; capture `adc_data` on the 2nd cycle.
  - UPD: 1 cycle, then back to ADDR if `en`, else IDLE.
- `address` holds its value from ADDR through READ.
- Timeout: a counter is reset on entry to WAITL and to WAITH. If it reaches `TO_CYC-1` in either state, set `timeout_err[ch]` and jump to UPD without a capture. In that case no `sample_valid` is issued and peak/valley are not updated.
- UPD, after a good capture: pulse `sample_valid` and compare unsigned.
  - If `fresh[ch]`, load peak=valley=sample and clear `fresh[ch]`.
  - Otherwise peak=max(peak, sample) and valley=min(valley, sample).
- Channel advance in UPD: `ch` = (ch==NCH-1) ? 0 : ch+1. On wrap, pulse `scan_done`; a timed-out channel still counts toward the scan.
- `clr` sets all `fresh` bits and clears `timeout_err` the same cycle. Peak/valley values hold until each channel's next good update.
- `clr` coincident with UPD of channel k: channel k loads the sample and `fresh[k]` ends cleared. Every other channel ends fresh.
- `en` dropped mid-conversion: the current conversion completes through UPD, then the FSM goes to IDLE. `ch` is retained, and resumption continues at the next channel.
- `adc_clock` toggles every `CLK_DIV` cycles, independent of FSM and `en`.

## Timing
- Reset values:
  - `start`=`ale`=`oe`=0, `address`=0, `adc_clock`=0.
  - `sample_*`=0, strobes 0, `timeout_err`=0.
  - `peak_out`=0, `valley_out`=all ones, all `fresh`=1, `ch`=0, FSM=IDLE.
- Reset mid-operation aborts the FSM immediately; all outputs take their reset values asynchronously.
- Per channel: ADDR 1 + START 2 + WAITL (≥1) + WAITH (≥1) + READ 2 + UPD 1 cycles.
- `eoc` edge to FSM reaction is 2 cycles.
- `sample_valid`, `sample_out`, `sample_ch` and the updated peak/valley change together in the cycle after UPD. All outputs are registered.
- `scan_done` is coincident with the `sample_valid` (or timeout update) of channel `NCH-1`.

## Structure
- Package `adc_scan_pkg`:
  - FSM state enum {IDLE, ADDR, START, WAITL, WAITH, READ, UPD}.
  - START/READ width constants (2).
  - Sync stage count (2).
- Sub-module `adc_peak_cell`: one per channel via generate. Inputs: `clock`, `reset`, `load`, `fresh_set`, `sample`. Outputs: `peak`, `valley`, `fresh`.
- Top holds the FSM, synchronizer, timeout counter and clock divider.

## Test plan
- Reset, then `en`=1, NCH=4, ADC model returns 0x40,0x80,0x10,0xFF for ch0..3.
  - `address` sequence 0,1,2,3,0.
  - After the first `scan_done`: `peak_out`=`valley_out`=0xFF108040.
- Channel 1 fed 0x80, 0x20, 0x90 over 3 scans -> peak[1]=0x90, valley[1]=0x20.
- Pulse `clr` during channel-2 WAITH, then feed 0x05 everywhere -> after the next scan, every channel's peak=valley=0x05 and `timeout_err`=0.
- Channel 3 never drops `eoc`, TO_CYC=16:
  - `timeout_err`=4'b1000 within 16 cycles of WAITL entry.
  - No `sample_valid` for ch3, and `scan_done` still pulses.
- `en` deasserted during ch1 READ -> ch1 still updates, FSM goes to IDLE with no further `start`. Re-enable -> first `address`=2.
- Assert `reset` low during START -> `start`/`ale`/`oe` drop to 0 the same cycle. After release, the scan restarts at ch0 with all channels fresh.
- CLK_DIV=3 -> `adc_clock` period is 6 `clock` cycles in every state.

Source files
------------

// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_pkg
// Purpose  : Shared types and constants for the ADC round-robin peak scanner.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package adc_scan_pkg;

    // Conversion sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        START = 3'd2,
        WAITL = 3'd3,
        WAITH = 3'd4,
        READ  = 3'd5,
        UPD   = 3'd6
    } scan_state_t;

    // Cycles spent with ale/start high, and with oe high.
    localparam int c_start_cyc   = 2;
    localparam int c_read_cyc    = 2;

    // Flops in the eoc synchronizer chain.
    localparam int c_sync_stages = 2;

    // ADC mux address width (fixed by the converter pinout).
    localparam int c_addr_w      = 3;

endpackage
`default_nettype wire

// File: rtl/adc_peak_cell.sv
`default_nettype none
// ============================================================================
// Module   : adc_peak_cell
// Purpose  : Per-channel running max/min over a clearable window. A "fresh"
//            channel loads the next sample as both peak and valley.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module adc_peak_cell #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          fresh_set,
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] peak,
    output logic [DW-1:0] valley,
    output logic          fresh
);

    logic [DW-1:0] r_peak;
    logic [DW-1:0] r_valley;
    logic          r_fresh;

    // Window update: a load coincident with a window open counts as the
    // first sample of the new window, so the channel ends non-fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_peak   <= '0;
            r_valley <= '1;
            r_fresh  <= 1'b1;
        end else if (load) begin
            if (r_fresh || fresh_set) begin
                r_peak   <= sample;
                r_valley <= sample;
            end else begin
                if (sample > r_peak) begin
                    r_peak <= sample;
                end
                if (sample < r_valley) begin
                    r_valley <= sample;
                end
            end
            r_fresh <= 1'b0;
        end else if (fresh_set) begin
            r_fresh <= 1'b1;
        end
    end

    assign peak   = r_peak;
    assign valley = r_valley;
    assign fresh  = r_fresh;

endmodule
`default_nettype wire

// File: rtl/adc_peak_scan.sv
`default_nettype none
// ============================================================================
// Module   : adc_peak_scan
// Purpose  : Round-robin ADC0809-class sequencer with per-channel peak/valley
//            hold, eoc timeout detection and a free-running ADC clock.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module adc_peak_scan
    import adc_scan_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int CLK_DIV = 8,
    parameter int TO_CYC  = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                clr,
    input  logic                eoc,
    input  logic [DW-1:0]       adc_data,
    output logic                adc_clock,
    output logic                start,
    output logic                ale,
    output logic                oe,
    output logic [c_addr_w-1:0] address,
    output logic [DW-1:0]       sample_out,
    output logic [c_addr_w-1:0] sample_ch,
    output logic                sample_valid,
    output logic                scan_done,
    output logic [NCH*DW-1:0]   peak_out,
    output logic [NCH*DW-1:0]   valley_out,
    output logic [NCH-1:0]      timeout_err
);

    // The state counter doubles as START/READ phase counter and eoc timeout
    // counter; it must hold at least TO_CYC-1 and the phase limits.
    localparam int c_cnt_w = ($clog2(TO_CYC) > 2) ? $clog2(TO_CYC) : 2;
    localparam int c_div_w = ($clog2(CLK_DIV) > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_cnt_w-1:0]  c_to_last    = c_cnt_w'(TO_CYC - 1);
    localparam logic [c_cnt_w-1:0]  c_start_last = c_cnt_w'(c_start_cyc - 1);
    localparam logic [c_cnt_w-1:0]  c_read_last  = c_cnt_w'(c_read_cyc - 1);
    localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [c_addr_w-1:0] c_last_ch    = c_addr_w'(NCH - 1);

    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [c_cnt_w-1:0]        r_cnt;

    logic [c_sync_stages-1:0]  r_eoc_sync;
    logic                      w_eoc_s;

    logic [c_div_w-1:0]        r_div_cnt;
    logic                      r_adc_clk;

    logic [c_addr_w-1:0]       r_ch;
    logic [c_addr_w-1:0]       w_ch_nxt;
    logic [DW-1:0]             r_data;
    logic                      r_good;

    logic                      r_start;
    logic                      r_ale;
    logic                      r_oe;
    logic [c_addr_w-1:0]       r_address;
    logic [DW-1:0]             r_sample_out;
    logic [c_addr_w-1:0]       r_sample_ch;
    logic                      r_sample_valid;
    logic                      r_scan_done;
    logic [NCH-1:0]            r_timeout_err;

    logic                      w_timeout;
    logic                      w_start_nxt;
    logic                      w_oe_nxt;
    logic                      w_capture;
    logic                      w_upd;
    logic                      w_load_good;
    logic                      w_wrap;
    logic [NCH-1:0]            w_load;
    logic [NCH-1:0]            w_err_set;
    // Window state lives inside each cell; the top only observes it.
    logic [NCH-1:0]            w_fresh_unused;

    assign w_eoc_s = r_eoc_sync[c_sync_stages-1];

    // eoc comes from the converter's own clock domain; resynchronise it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_eoc_sync <= '0;
        end else begin
            r_eoc_sync <= {r_eoc_sync[c_sync_stages-2:0], eoc};
        end
    end

    // Free-running 50% ADC clock, unaffected by the sequencer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_div_cnt <= '0;
            r_adc_clk <= 1'b0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
            r_adc_clk <= ~r_adc_clk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // State register; the counter restarts on every state change.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state logic; eoc response wins over a timeout in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE:  if (en) w_state_nxt = ADDR;
            ADDR:  w_state_nxt = START;
            START: if (r_cnt == c_start_last) w_state_nxt = WAITL;
            WAITL: begin
                if (!w_eoc_s) begin
                    w_state_nxt = WAITH;
                end else if (r_cnt == c_to_last) begin
                    w_state_nxt = UPD;
                    w_timeout   = 1'b1;
                end
            end
            WAITH: begin
                if (w_eoc_s) begin
                    w_state_nxt = READ;
                end else if (r_cnt == c_to_last) begin
                    w_state_nxt = UPD;
                    w_timeout   = 1'b1;
                end
            end
            READ:  if (r_cnt == c_read_last) w_state_nxt = UPD;
            UPD:   w_state_nxt = en ? ADDR : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the next state so the registered pins line up
    // exactly with the state they belong to.
    always_comb begin
        w_start_nxt = (w_state_nxt == START);
        w_oe_nxt    = (w_state_nxt == READ);
        w_capture   = (r_state == READ) && (r_cnt == c_read_last);
        w_upd       = (r_state == UPD);
        w_load_good = w_upd && r_good;
        w_wrap      = (r_ch == c_last_ch);
        w_ch_nxt    = r_ch;
        if (w_upd) begin
            w_ch_nxt = w_wrap ? '0 : r_ch + 1'b1;
        end
        for (int k = 0; k < NCH; k++) begin
            w_load[k]    = w_load_good && (r_ch == c_addr_w'(k));
            w_err_set[k] = w_timeout && (r_ch == c_addr_w'(k));
        end
    end

    // Registered pins, capture path, channel pointer and sticky errors.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_start        <= 1'b0;
            r_ale          <= 1'b0;
            r_oe           <= 1'b0;
            r_address      <= '0;
            r_data         <= '0;
            r_good         <= 1'b0;
            r_sample_out   <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            r_ch           <= '0;
            r_timeout_err  <= '0;
        end else begin
            r_start <= w_start_nxt;
            r_ale   <= w_start_nxt;
            r_oe    <= w_oe_nxt;
            if (w_state_nxt == ADDR) begin
                r_address <= w_ch_nxt;
                r_good    <= 1'b0;
            end else if (w_capture) begin
                r_good    <= 1'b1;
            end
            if (w_capture) begin
                r_data <= adc_data;
            end
            r_sample_valid <= w_load_good;
            if (w_load_good) begin
                r_sample_out <= r_data;
                r_sample_ch  <= r_ch;
            end
            r_scan_done <= w_upd && w_wrap;
            r_ch        <= w_ch_nxt;
            // A timeout in the same cycle as clr still records the error.
            r_timeout_err <= (clr ? '0 : r_timeout_err) | w_err_set;
        end
    end

    // One peak/valley tracker per channel, packed ch0 in the LSBs.
    for (genvar k = 0; k < NCH; k++) begin : g_cell
        adc_peak_cell #(
            .DW (DW)
        ) u_cell (
            .clock     (clock),
            .reset     (reset),
            .load      (w_load[k]),
            .fresh_set (clr),
            .sample    (r_data),
            .peak      (peak_out[k*DW +: DW]),
            .valley    (valley_out[k*DW +: DW]),
            .fresh     (w_fresh_unused[k])
        );
    end

    assign adc_clock    = r_adc_clk;
    assign start        = r_start;
    assign ale          = r_ale;
    assign oe           = r_oe;
    assign address      = r_address;
    assign sample_out   = r_sample_out;
    assign sample_ch    = r_sample_ch;
    assign sample_valid = r_sample_valid;
    assign scan_done    = r_scan_done;
    assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_adc_peak_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_peak_scan
// Purpose  : Self-checking bench: behavioural ADC0809 model, sample
//            scoreboard, per-scan peak/valley vector table, corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_peak_scan;

    localparam int NCH     = 4;
    localparam int DW      = 8;
    localparam int CLK_DIV = 3;
    localparam int TO_CYC  = 16;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic              en       = 1'b0;
    logic              clr      = 1'b0;
    logic              eoc      = 1'b1;
    logic [DW-1:0]     adc_data = '0;
    logic              adc_clock, start, ale, oe, sample_valid, scan_done;
    logic [2:0]        address, sample_ch;
    logic [DW-1:0]     sample_out;
    logic [NCH*DW-1:0] peak_out, valley_out;
    logic [NCH-1:0]    timeout_err;

    adc_peak_scan #(
        .NCH(NCH), .DW(DW), .CLK_DIV(CLK_DIV), .TO_CYC(TO_CYC)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .clr(clr), .eoc(eoc),
        .adc_data(adc_data), .adc_clock(adc_clock), .start(start), .ale(ale),
        .oe(oe), .address(address), .sample_out(sample_out),
        .sample_ch(sample_ch), .sample_valid(sample_valid),
        .scan_done(scan_done), .peak_out(peak_out), .valley_out(valley_out),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string msg);
        n_checks++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // ---------------- ADC model and scoreboard ----------------
    typedef struct { logic [2:0] ch; logic [DW-1:0] val; } exp_t;
    exp_t           sb_q[$];
    int             addr_hist[$];
    int             sv_cnt [NCH];
    logic [DW-1:0]  mdata  [NCH];
    logic [NCH-1:0] stuck = '0;
    int             m_state = 0;
    int             m_cnt   = 0;
    int             m_ch    = 0;

    // Converter: eoc drops one cycle after start ends, rises 4 cycles later,
    // data is presented once oe goes high. A stuck channel never drops eoc.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_state  = 0;
                eoc      = 1'b1;
                adc_data = '0;
            end else begin
                case (m_state)
                    0: if (start) begin
                        m_ch = int'(address);
                        addr_hist.push_back(m_ch);
                        m_state = 1;
                    end
                    1: if (!start) begin
                        if (stuck[m_ch]) m_state = 0;
                        else begin eoc = 1'b0; m_cnt = 0; m_state = 2; end
                    end
                    2: begin
                        m_cnt++;
                        if (m_cnt == 4) begin eoc = 1'b1; m_state = 3; end
                    end
                    3: if (oe) begin
                        adc_data = mdata[m_ch];
                        sb_q.push_back('{3'(m_ch), mdata[m_ch]});
                        m_state = 0;
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    // Every sample_valid must match the oldest conversion the model served.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                sb_q.delete();
            end else if (sample_valid) begin
                if (sb_q.size() == 0) begin
                    fail_now("sb_unexpected", $sformatf("sample ch%0d=0x%0h with nothing pending", sample_ch, sample_out));
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_ch", 64'(sample_ch), 64'(e.ch));
                    check("sb_data", 64'(sample_out), 64'(e.val));
                end
                if (int'(sample_ch) < NCH) sv_cnt[sample_ch]++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic set_data(input logic [31:0] d);
        for (int k = 0; k < NCH; k++) mdata[k] = d[k*8 +: 8];
    endtask

    task automatic wait_scan(input string name);
        bit got = 0;
        for (int i = 0; i < 800 && !got; i++) begin
            @(negedge clock);
            if (scan_done) got = 1;
        end
        if (!got) fail_now(name, "no scan_done within 800 cycles");
    endtask

    task automatic measure_clk(input string name);
        logic prev;
        int   last = -1;
        int   bad = 0;
        int   toggles = 0;
        @(posedge clock); #1 prev = adc_clock;
        for (int i = 1; i <= 36; i++) begin
            @(posedge clock); #1;
            if (adc_clock !== prev) begin
                if (last >= 0 && (i - last) != CLK_DIV) bad++;
                last = i;
                toggles++;
                prev = adc_clock;
            end
        end
        check({name, "_bad_half_periods"}, 64'(bad), 64'd0);
        check({name, "_toggles"}, 64'(toggles), 64'd12);
    endtask

    typedef struct packed {
        logic [31:0]    data;
        logic [NCH-1:0] stk;
        logic [31:0]    peak;
        logic [31:0]    valley;
        logic [NCH-1:0] err;
    } vec_t;
    vec_t vecs [4];

    // ---------------- main sequence ----------------
    initial begin
        bit   got;
        int   n, h, s1, s3;

        vecs[0] = '{32'hFF108040, 4'b0000, 32'hFF108040, 32'hFF108040, 4'b0000};
        vecs[1] = '{32'hFE082050, 4'b0000, 32'hFF108050, 32'hFE082040, 4'b0000};
        vecs[2] = '{32'hFF209030, 4'b0000, 32'hFF209050, 32'hFE082030, 4'b0000};
        vecs[3] = '{32'h00209060, 4'b1000, 32'hFF209060, 32'hFE082030, 4'b1000};
        for (int k = 0; k < NCH; k++) sv_cnt[k] = 0;

        // Reset values, held for several cycles.
        repeat (10) @(negedge clock);
        check("rst_start", 64'(start), 64'd0);
        check("rst_ale", 64'(ale), 64'd0);
        check("rst_oe", 64'(oe), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_adc_clock", 64'(adc_clock), 64'd0);
        check("rst_sample_out", 64'(sample_out), 64'd0);
        check("rst_sample_ch", 64'(sample_ch), 64'd0);
        check("rst_sample_valid", 64'(sample_valid), 64'd0);
        check("rst_scan_done", 64'(scan_done), 64'd0);
        check("rst_peak", 64'(peak_out), 64'd0);
        check("rst_valley", 64'(valley_out), 64'hFFFFFFFF);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);

        set_data(vecs[0].data);
        stuck = vecs[0].stk;
        reset = 1'b1;
        en    = 1'b1;
        measure_clk("adc_clk_active");

        // Table: one scan per vector, cumulative peak/valley.
        for (int i = 0; i < 4; i++) begin
            set_data(vecs[i].data);
            stuck = vecs[i].stk;
            wait_scan($sformatf("vec%0d_scan", i));
            check($sformatf("vec%0d_peak", i), 64'(peak_out), 64'(vecs[i].peak));
            check($sformatf("vec%0d_valley", i), 64'(valley_out), 64'(vecs[i].valley));
            check($sformatf("vec%0d_err", i), 64'(timeout_err), 64'(vecs[i].err));
        end

        for (int i = 0; i < 5; i++) begin
            if (addr_hist.size() > i) check($sformatf("addr_seq%0d", i), 64'(addr_hist[i]), 64'(i % NCH));
            else fail_now($sformatf("addr_seq%0d", i), "missing start");
        end

        // clr during channel 2 WAITH: ch0/ch1 hold old window values for
        // this scan, everyone reloads fresh on the next.
        stuck = '0;
        set_data(32'h05057070);
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock); #1;
            if (eoc == 1'b0 && address == 3'd2) got = 1;
        end
        if (!got) fail_now("clr_find_ch2", "ch2 conversion not seen");
        repeat (3) @(posedge clock);
        #1 clr = 1'b1;
        set_data(32'h05050505);
        @(posedge clock);
        #1 clr = 1'b0;
        wait_scan("clr_scan1");
        check("clr_scan1_peak", 64'(peak_out), 64'h05059070);
        check("clr_scan1_valley", 64'(valley_out), 64'h05052030);
        check("clr_scan1_err", 64'(timeout_err), 64'd0);
        wait_scan("clr_scan2");
        check("clr_scan2_peak", 64'(peak_out), 64'h05050505);
        check("clr_scan2_valley", 64'(valley_out), 64'h05050505);
        check("clr_scan2_err", 64'(timeout_err), 64'd0);

        // Channel 3 never answers: error after exactly TO_CYC WAITL cycles.
        stuck = 4'b1000;
        s3 = sv_cnt[3];
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (start && address == 3'd3) got = 1;
        end
        if (!got) fail_now("to_find_ch3", "ch3 start not seen");
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (!start) got = 1;
        end
        n = 0;
        got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(negedge clock);
            if (timeout_err[3]) begin got = 1; n = i; end
        end
        check("timeout_latency", 64'(n), 64'(TO_CYC));
        wait_scan("timeout_scan_done");
        check("timeout_err_vec", 64'(timeout_err), 64'h8);
        check("timeout_no_ch3_sample", 64'(sv_cnt[3]), 64'(s3));
        check("timeout_peak_hold", 64'(peak_out), 64'h05050505);
        stuck = '0;

        // en dropped in ch1 READ: ch1 completes, then idle; resume at ch2.
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clock);
            if (oe && address == 3'd1) got = 1;
        end
        if (!got) fail_now("en_find_ch1", "ch1 READ not seen");
        en = 1'b0;
        h  = addr_hist.size();
        s1 = sv_cnt[1];
        repeat (60) @(negedge clock);
        check("en_ch1_completed", 64'(sv_cnt[1]), 64'(s1 + 1));
        check("en_no_new_start", 64'(addr_hist.size()), 64'(h));
        en = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (addr_hist.size() > h) got = 1;
        end
        if (got) check("en_resume_addr", 64'(addr_hist[h]), 64'd2);
        else fail_now("en_resume_addr", "no start after re-enable");

        // Asynchronous reset in START.
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock);
            if (start) got = 1;
        end
        if (!got) fail_now("rst_find_start", "start not seen");
        #2 reset = 1'b0;
        #1;
        check("arst_start", 64'(start), 64'd0);
        check("arst_ale", 64'(ale), 64'd0);
        check("arst_oe", 64'(oe), 64'd0);
        check("arst_peak", 64'(peak_out), 64'd0);
        check("arst_valley", 64'(valley_out), 64'hFFFFFFFF);
        check("arst_err", 64'(timeout_err), 64'd0);
        repeat (3) @(negedge clock);
        addr_hist.delete();
        set_data(32'hFF108040);
        reset = 1'b1;
        wait_scan("arst_rescan");
        check("arst_rescan_peak", 64'(peak_out), 64'hFF108040);
        check("arst_rescan_valley", 64'(valley_out), 64'hFF108040);
        if (addr_hist.size() > 0) check("arst_first_addr", 64'(addr_hist[0]), 64'd0);
        else fail_now("arst_first_addr", "no start after reset");

        // ADC clock keeps running with the sequencer idle.
        en = 1'b0;
        repeat (40) @(negedge clock);
        measure_clk("adc_clk_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
